frame_port_arbiter: RTL

Shares the single trace packet buffer read port (FrameNext/FrameReady/FramesCnt) between two frame uploaders: requester 0 is the SPI uploader, requester 1 is a second upload path such as the serial/USB uploader. One requester holds the buffer for an entire transmit burst, signalled by its Transmitting level. Grants rotate round-robin, with an enforced idle gap between owners. Frame data fans out from the buffer to both requesters directly; only pop control passes through this block.

---
 rtl/frame_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/frame_port_arbiter.sv
// Round-robin owner of the trace packet buffer read port for two frame uploaders,
// with an idle gap between owners. Define FRAME_ARB_STATS_EN to build the refusal counters.
module frame_port_arbiter #(
  parameter int BUFFLENLOG2 = 9,
  parameter int HOLDOFF     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   FrameNext,
  input  logic                   FrameReady,
  input  logic [BUFFLENLOG2-1:0] FramesCnt,
  input  logic                   ReqActive0,
  input  logic                   FrameNext0,
  output logic                   FrameReady0,
  output logic                   Grant0,
  input  logic                   ReqActive1,
  input  logic                   FrameNext1,
  output logic                   FrameReady1,
  output logic                   Grant1,
  output logic [1:0]             Owner,
  output logic [7:0]             Denied0,
  output logic [7:0]             Denied1,
  output logic [7:0]             Underrun
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, HOLD} state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF - 1);

  state_t     state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       grant0_q, grant0_d;
  logic       grant1_q, grant1_d;
  logic       buf_nonempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= 4'd0;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      grant0_q     <= grant0_d;
      grant1_q     <= grant1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        // On a tie the requester that did not own the buffer last time wins.
        if (ReqActive0 && ReqActive1) state_d = last_owner_q ? GRANT0 : GRANT1;
        else if (ReqActive0)          state_d = GRANT0;
        else if (ReqActive1)          state_d = GRANT1;
      end
      GRANT0: begin
        if (!ReqActive0) begin
          state_d      = HOLD;
          last_owner_d = 1'b0;
          hold_cnt_d   = HOLD_LOAD;
        end
      end
      GRANT1: begin
        if (!ReqActive1) begin
          state_d      = HOLD;
          last_owner_d = 1'b1;
          hold_cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == 4'd0) state_d = IDLE;
        else                    hold_cnt_d = hold_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant flops are loaded from the next state so they track state_q exactly.
  always_comb begin
    grant0_d = (state_d == GRANT0);
    grant1_d = (state_d == GRANT1);
  end

  assign buf_nonempty = (FramesCnt != '0);
  assign Grant0       = grant0_q;
  assign Grant1       = grant1_q;
  assign Owner        = {grant1_q, grant0_q};
  assign FrameReady0  = FrameReady & grant0_q;
  assign FrameReady1  = FrameReady & grant1_q;
  assign FrameNext    = ((FrameNext0 & grant0_q) | (FrameNext1 & grant1_q)) & buf_nonempty;

`ifdef FRAME_ARB_STATS_EN
  logic [7:0] denied0_q, denied0_d;
  logic [7:0] denied1_q, denied1_d;
  logic [7:0] underrun_q, underrun_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
    return (en && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  always_comb begin
    denied0_d  = sat_inc(denied0_q, FrameNext0 & ~grant0_q);
    denied1_d  = sat_inc(denied1_q, FrameNext1 & ~grant1_q);
    underrun_d = sat_inc(underrun_q,
                         ((FrameNext0 & grant0_q) | (FrameNext1 & grant1_q)) & ~buf_nonempty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      denied0_q  <= 8'd0;
      denied1_q  <= 8'd0;
      underrun_q <= 8'd0;
    end else begin
      denied0_q  <= denied0_d;
      denied1_q  <= denied1_d;
      underrun_q <= underrun_d;
    end
  end

  assign Denied0  = denied0_q;
  assign Denied1  = denied1_q;
  assign Underrun = underrun_q;
`else
  assign Denied0  = 8'd0;
  assign Denied1  = 8'd0;
  assign Underrun = 8'd0;
`endif

endmodule
